// File: rtl/sum4_host.sv
// sum4_host
//   Initiator-side controller for the four-operand 8-bit sum datapath.
//   Accepts a request (operands + mode) on a valid/ready port, launches the
//   datapath with a one-cycle start pulse, waits for done (guarded by a
//   watchdog), then presents the captured result on a valid/ready response
//   port. A wrapping 8-bit counter tracks completed responses.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (req_ready high only in IDLE)
//   req_mode, req_data   request mode and packed operands {d,c,b,a}
//   a, b, c, d, mode     registered operand/mode buses to the datapath
//   start                one-cycle launch pulse
//   done, error, sum     datapath completion and result (valid with done)
//   rsp_valid/rsp_ready  response handshake
//   rsp_sum, rsp_error,
//   rsp_timeout          captured response fields
//   txn_count            completed responses, modulo 256
module sum4_host #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [31:0] req_data,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [7:0]  c,
  output logic [7:0]  d,
  output logic        mode,
  output logic        start,
  input  logic        done,
  input  logic        error,
  input  logic [7:0]  sum,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_sum,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic [7:0]  txn_count
);

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ops_q, ops_d;
  logic        mode_q, mode_d;
  logic        start_q, start_d;
  logic [7:0]  wd_q, wd_d;
  logic [7:0]  wd_inc;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_sum_q, rsp_sum_d;
  logic        rsp_error_q, rsp_error_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [7:0]  txn_q, txn_d;

  assign wd_inc = wd_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    ops_d         = ops_q;
    mode_d        = mode_q;
    start_d       = 1'b0;
    wd_d          = wd_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_sum_d     = rsp_sum_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    txn_d         = txn_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ops_d   = req_data;
          mode_d  = req_mode;
          wd_d    = 8'd0;
          start_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // done is deliberately not looked at here: the datapath has only
        // just seen start, so any done now is stale.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          // done takes priority even on the cycle the watchdog would expire
          rsp_sum_d     = sum;
          rsp_error_d   = error;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == TIMEOUT_W) begin
            rsp_sum_d     = 8'd0;
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            state_d       = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_d       = txn_q + 8'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ops_q         <= 32'd0;
      mode_q        <= 1'b0;
      start_q       <= 1'b0;
      wd_q          <= 8'd0;
      rsp_valid_q   <= 1'b0;
      rsp_sum_q     <= 8'd0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      txn_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      ops_q         <= ops_d;
      mode_q        <= mode_d;
      start_q       <= start_d;
      wd_q          <= wd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_sum_q     <= rsp_sum_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      txn_q         <= txn_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign a           = ops_q[7:0];
  assign b           = ops_q[15:8];
  assign c           = ops_q[23:16];
  assign d           = ops_q[31:24];
  assign mode        = mode_q;
  assign start       = start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_sum     = rsp_sum_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
  assign txn_count   = txn_q;

endmodule
